// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback result mux, 32x32 integer regfile with x0=0, commit counter
// Optional build macro: WB_BYPASS_EN (same-cycle write-through on both read ports).
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [XLEN-1:0]  ALUResultW,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic [XLEN-1:0]  PC_plus4W,
    input  logic [XLEN-1:0]  lAuiPCW,
    input  logic [4:0]       RdW,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    output logic [XLEN-1:0]  RD1D,
    output logic [XLEN-1:0]  RD2D,
    output logic [XLEN-1:0]  ResultW,
    output logic             WbValidW,
    output logic [CNT_W-1:0] WbCount
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [CNT_W-1:0] r_wb_count;
    logic [XLEN-1:0]  w_result;
    logic             w_wb_valid;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;

    always_comb begin
        w_result = ALUResultW;
        case (ResultSrcW)
            2'b00:   w_result = ALUResultW;
            2'b01:   w_result = ReadDataW;
            2'b10:   w_result = PC_plus4W;
            default: w_result = lAuiPCW;
        endcase
    end

    assign w_wb_valid = RegWriteW && (RdW != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count <= '0;
        end else if (w_wb_valid) begin
            r_regs[RdW] <= w_result;
            r_wb_count  <= r_wb_count + CNT_W'(1);
        end
    end

    // x0 and reset override everything, including the bypass path
    always_comb begin
        w_rd1 = r_regs[Rs1D];
        w_rd2 = r_regs[Rs2D];
`ifdef WB_BYPASS_EN
        if (w_wb_valid && (Rs1D == RdW)) w_rd1 = w_result;
        if (w_wb_valid && (Rs2D == RdW)) w_rd2 = w_result;
`else
`endif
        if (!rst_n || (Rs1D == 5'd0)) w_rd1 = '0;
        if (!rst_n || (Rs2D == 5'd0)) w_rd2 = '0;
    end

    assign RD1D     = w_rd1;
    assign RD2D     = w_rd2;
    assign ResultW  = w_result;
    assign WbValidW = w_wb_valid;
    assign WbCount  = r_wb_count;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile (default and WB_BYPASS_EN builds)
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW, ReadDataW, PC_plus4W, lAuiPCW;
    logic [4:0]  RdW, Rs1D, Rs2D;
    logic [31:0] RD1D, RD2D, ResultW, WbCount;
    logic        WbValidW;
    logic [31:0] w_rd1, w_rd2, w_res;
    logic        w_valid;
    logic [3:0]  w_cnt4;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PC_plus4W(PC_plus4W), .lAuiPCW(lAuiPCW),
        .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(RD1D), .RD2D(RD2D),
        .ResultW(ResultW), .WbValidW(WbValidW), .WbCount(WbCount)
    );

    // Narrow-counter instance sharing the same stimulus, used to reach the wrap point quickly
    wb_regfile #(.CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PC_plus4W(PC_plus4W), .lAuiPCW(lAuiPCW),
        .RdW(RdW), .Rs1D(Rs1D), .Rs2D(Rs2D), .RD1D(w_rd1), .RD2D(w_rd2),
        .ResultW(w_res), .WbValidW(w_valid), .WbCount(w_cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam int S_RD1 = 0, S_RD2 = 1, S_RES = 2, S_VAL = 3, S_CNT = 4, S_CNT4 = 5;

    typedef struct {
        int          sel;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_regs [32];
    logic [31:0] model_count;
    bit          bypass;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD1:   return RD1D;
            S_RD2:   return RD2D;
            S_RES:   return ResultW;
            S_VAL:   return {31'd0, WbValidW};
            S_CNT:   return WbCount;
            default: return {28'd0, w_cnt4};
        endcase
    endfunction

    task automatic push(input int sel, input string tag, input logic [31:0] val);
        exp_t e;
        e.sel = sel;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_count = 32'd0;
    endtask

    task automatic commit(input logic we, input logic [4:0] rd, input logic [31:0] val);
        if (we && rd != 5'd0) begin
            model_regs[rd] = val;
            model_count    = model_count + 32'd1;
        end
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [31:0] val);
        @(negedge clk);
        RegWriteW  = 1'b1;
        RdW        = rd;
        ResultSrcW = 2'b00;
        ALUResultW = val;
        @(posedge clk);
        commit(1'b1, rd, val);
        #1;
        RegWriteW = 1'b0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s);
        case (s)
            2'b00:   return ALUResultW;
            2'b01:   return ReadDataW;
            2'b10:   return PC_plus4W;
            default: return lAuiPCW;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] rs, input logic [31:0] res);
        if (rs == 5'd0) return 32'd0;
        if (bypass && RegWriteW && RdW != 5'd0 && rs == RdW) return res;
        return model_regs[rs];
    endfunction

    logic [31:0] srcs [4];
    logic [31:0] res;

    initial begin
`ifdef WB_BYPASS_EN
        bypass = 1'b1;
`else
        bypass = 1'b0;
`endif
        model_reset();
        rst_n = 1'b0; RegWriteW = 1'b0; ResultSrcW = 2'b00; RdW = 5'd0;
        ALUResultW = 32'd0; ReadDataW = 32'd0; PC_plus4W = 32'd0; lAuiPCW = 32'd0;
        Rs1D = 5'd0; Rs2D = 5'd0;
        #12;
        push(S_CNT, "reset_count", 32'd0);
        push(S_RD1, "reset_rd1", 32'd0);
        drain();
        rst_n = 1'b1;

        // Asynchronous reset pulse between edges wipes x5 and the counter
        do_write(5'd5, 32'h1234);
        @(negedge clk);
        Rs1D = 5'd5;
        #1;
        push(S_RD1, "x5_written", 32'h1234);
        push(S_CNT, "count_one", 32'd1);
        drain();
        RegWriteW = 1'b1; RdW = 5'd5; ALUResultW = 32'h4321;
        rst_n = 1'b0;
        model_reset();
        #1;
        push(S_RD1, "async_reset_rd1", 32'd0);
        push(S_CNT, "async_reset_cnt", 32'd0);
        push(S_RES, "reset_resultw_comb", 32'h4321);
        push(S_VAL, "reset_valid_comb", 32'd1);
        drain();
        RegWriteW = 1'b0;
        #1 rst_n = 1'b1;

        // Result mux walk, all writing x3
        ALUResultW = 32'hA; ReadDataW = 32'hB; PC_plus4W = 32'hC; lAuiPCW = 32'hD;
        srcs[0] = 32'hA; srcs[1] = 32'hB; srcs[2] = 32'hC; srcs[3] = 32'hD;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            RegWriteW = 1'b1; RdW = 5'd3; ResultSrcW = 2'(s);
            #1;
            push(S_RES, $sformatf("mux_sel%0d", s), srcs[s]);
            drain();
            @(posedge clk);
            commit(1'b1, 5'd3, srcs[s]);
        end
        @(negedge clk);
        RegWriteW = 1'b0; Rs1D = 5'd3;
        #1;
        push(S_RD1, "x3_final", 32'hD);
        push(S_CNT, "mux_count", 32'd4);
        drain();

        // Writes to x0 are dropped
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'hFFFF_FFFF; Rs1D = 5'd0;
        #1;
        push(S_VAL, "x0_valid", 32'd0);
        push(S_RD1, "x0_same_cycle", 32'd0);
        drain();
        @(posedge clk);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        push(S_RD1, "x0_after", 32'd0);
        push(S_CNT, "x0_count", 32'd4);
        drain();

        // Same-cycle read/write of x7
        do_write(5'd7, 32'h1111);
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b00; ALUResultW = 32'h55AA;
        Rs1D = 5'd7; Rs2D = 5'd7;
        #1;
        push(S_RD1, "raw_rd1", bypass ? 32'h55AA : 32'h1111);
        push(S_RD2, "raw_rd2", bypass ? 32'h55AA : 32'h1111);
        drain();
        @(posedge clk);
        commit(1'b1, 5'd7, 32'h55AA);
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        push(S_RD1, "raw_next_rd1", 32'h55AA);
        push(S_RD2, "raw_next_rd2", 32'h55AA);
        push(S_CNT, "raw_count", 32'd6);
        drain();

        // Disabled write leaves x9 alone
        do_write(5'd9, 32'h99);
        @(negedge clk);
        RegWriteW = 1'b0; RdW = 5'd9; ALUResultW = 32'h77; Rs1D = 5'd9;
        #1;
        push(S_VAL, "wdis_valid", 32'd0);
        drain();
        @(posedge clk);
        @(negedge clk);
        #1;
        push(S_RD1, "wdis_x9", 32'h99);
        push(S_CNT, "wdis_count", 32'd7);
        drain();

        // Randomised traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            RegWriteW  = 1'($urandom_range(0, 1));
            RdW        = 5'($urandom_range(0, 31));
            ResultSrcW = 2'($urandom_range(0, 3));
            ALUResultW = $urandom; ReadDataW = $urandom; PC_plus4W = $urandom; lAuiPCW = $urandom;
            Rs1D       = (n % 3 == 0) ? RdW : 5'($urandom_range(0, 31));
            Rs2D       = 5'($urandom_range(0, 31));
            #1;
            res = pick(ResultSrcW);
            push(S_RES, "rand_res", res);
            push(S_VAL, "rand_valid", {31'd0, RegWriteW && RdW != 5'd0});
            push(S_RD1, "rand_rd1", exp_read(Rs1D, res));
            push(S_RD2, "rand_rd2", exp_read(Rs2D, res));
            push(S_CNT, "rand_count", model_count);
            drain();
            @(posedge clk);
            commit(RegWriteW, RdW, res);
        end
        @(negedge clk);
        RegWriteW = 1'b0;

        // Counter wrap on the 4-bit instance: all-ones, then one more valid write
        while (model_count[3:0] != 4'hF) do_write(5'd1, model_count);
        @(negedge clk);
        #1;
        push(S_CNT4, "wrap_all_ones", 32'hF);
        push(S_CNT, "wide_count", model_count);
        drain();
        do_write(5'd2, 32'hCAFE);
        @(negedge clk);
        #1;
        push(S_CNT4, "wrap_zero", 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback-stage consumer of the MEM/WB pipeline bundle.
- Selects the final result from the four WB-stage sources.
- Commits it into a 32x32 integer register file with x0 hardwired to zero.
- Serves the two decode-stage read ports and exports the selected result for EX-stage forwarding.
- Keeps a running count of committed register writes for debug.

Parameters:
XLEN, 32, data width of registers and all result sources
NREGS, 32, number of architectural registers; index width is 5 bits at the default
CNT_W, 32, width of the write-commit counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
RegWriteW  input  1  WB-stage register write enable
ResultSrcW  input  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PC_plus4W, 11 lAuiPCW
ALUResultW  input  XLEN  ALU result
ReadDataW  input  XLEN  load data
PC_plus4W  input  XLEN  link address for JAL/JALR
lAuiPCW  input  XLEN  LUI/AUIPC result
RdW  input  5  destination register index
Rs1D  input  5  decode read index 1
Rs2D  input  5  decode read index 2
RD1D  output  XLEN  read data 1
RD2D  output  XLEN  read data 2
ResultW  output  XLEN  selected WB result, for forwarding
WbValidW  output  1  high when a real write commits this cycle (RegWriteW and RdW != 0)
WbCount  output  CNT_W  number of committed writes since reset

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset state, entered immediately on rst_n falling: all registers x1..x31 = 0, WbCount = 0.
- While rst_n is low:
  - Writes are blocked.
  - Reads return 0.
  - ResultW and WbValidW stay combinational from the inputs.
- Reset asserted mid-operation: any write pending on the next edge is discarded.
- First write possible: the first rising clk edge after rst_n deasserts.
- Result mux: ResultW is purely combinational from ResultSrcW and the four sources. Zero cycles of latency, no register.
- Write: on rising clk, if RegWriteW = 1 and RdW != 0, then regs[RdW] <= ResultW.
  - RdW = 0 writes are silently dropped.
  - x0 always reads 0.
- WbValidW = RegWriteW and (RdW != 0), combinational.
- WbCount increments by 1 on each rising edge where WbValidW = 1.
  - Wraps from all-ones to 0.
  - No saturation, no overflow flag.
- Reads are combinational from the array: RD1D = regs[Rs1D], RD2D = regs[Rs2D]. Index 0 gives 0.
- Same-cycle read and write to the same index: governed by the optional feature below.
- Both read ports addressing the same register is legal. Both return the same value.
- No stall or flush inputs. Upstream squashes an instruction by driving RegWriteW = 0.

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: a write-through bypass is active on both read ports.
  - If WbValidW = 1 and RsxD == RdW, RDxD = ResultW in the same cycle.
  - This removes the WB-to-decode RAW hazard without a stall.
- Not defined: reads always return the array contents. A same-cycle read of RdW returns the old value, and the hazard unit must stall one cycle.
- In both builds, x0 reads 0 even when RdW = 0 with RegWriteW = 1.

Test Plan:
1. Reset: pulse rst_n low between clock edges after writing x5 = 0x1234 -> RD1D for Rs1D = 5 reads 0 immediately, before any edge; WbCount = 0.
2. Mux select: ALUResultW = 0xA, ReadDataW = 0xB, PC_plus4W = 0xC, lAuiPCW = 0xD; step ResultSrcW through 00..11 with RdW = 3 and RegWriteW = 1 -> ResultW is 0xA, 0xB, 0xC, 0xD; x3 = 0xD after the fourth edge; WbCount = 4.
3. x0 protection: RegWriteW = 1, RdW = 0, ALUResultW = 0xFFFFFFFF -> WbValidW = 0, RD1D for Rs1D = 0 stays 0, WbCount unchanged.
4. Same-cycle RAW: write x7 = 0x55AA, Rs1D = Rs2D = 7 in the same cycle -> with WB_BYPASS_EN both ports read 0x55AA that cycle; without it both read the old value, then 0x55AA on the next cycle.
5. Write disabled: RegWriteW = 0, RdW = 9, ALUResultW = 0x77 -> x9 unchanged, WbValidW = 0, WbCount unchanged.
6. Counter wrap: preload so WbCount = 0xFFFFFFFF (CNT_W = 32), then one valid write -> WbCount = 0.
